mc_ctrl: RTL and testbench

- Multi-cycle main controller that sequences the instruction-fetch unit and the rest of the datapath through IF/ID/EX/MEM/WB states.
- Drives PC/IR write strobes and next-PC selection (NPCop/Branchop) to the fetch unit, plus register-file, data-memory and ALU controls.
- Decodes opcode/funct from the instruction register and supports a hold input for wait-states.
- Counts retired instructions for the test bench.

---
 rtl/mc_ctrl_if.sv | 36 +++
 rtl/mc_ctrl.sv | 140 ++++++++++++++
 tb/tb_mc_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_if.sv
// Control bus of the multi-cycle main controller: IR fields and hold in,
// fetch/datapath strobes, mux selects and debug/retire information out.
interface mc_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             hold;
  logic             PCWr;
  logic             IRWr;
  logic [1:0]       NPCop;
  logic [2:0]       Branchop;
  logic [2:0]       ALUop;
  logic             ALUSrc;
  logic             RegWr;
  logic [1:0]       RegDst;
  logic [1:0]       WDSel;
  logic             MemWr;
  logic [2:0]       state;
  logic             retire;
  logic [CNT_W-1:0] instr_cnt;

  // Controller side
  modport master (
    input  opcode, funct, hold,
    output PCWr, IRWr, NPCop, Branchop, ALUop, ALUSrc, RegWr, RegDst,
           WDSel, MemWr, state, retire, instr_cnt
  );

  // Datapath / environment side
  modport slave (
    output opcode, funct, hold,
    input  PCWr, IRWr, NPCop, Branchop, ALUop, ALUSrc, RegWr, RegDst,
           WDSel, MemWr, state, retire, instr_cnt
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: sequences IF/ID/EX/MEM/WB, decodes the IR
// opcode/funct into datapath controls and counts retired instructions.
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic      clk,
  input  logic      reset,
  mc_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;

  logic isR, isAddu, isSubu, isJr, isOri, isLui, isLw, isSw, isBeq, isJ, isJal;
  logic pcWr, irWr, regWr, memWr, retireRaw;
  logic [1:0] npcOp, regDst, wdSel;
  logic [2:0] aluOp;
  logic       aluSrc;
  logic       strobeEn;

  assign isR    = (bus.opcode == 6'h00);
  assign isAddu = isR && (bus.funct == 6'h21);
  assign isSubu = isR && (bus.funct == 6'h23);
  assign isJr   = isR && (bus.funct == 6'h08);
  assign isOri  = (bus.opcode == 6'h0d);
  assign isLui  = (bus.opcode == 6'h0f);
  assign isLw   = (bus.opcode == 6'h23);
  assign isSw   = (bus.opcode == 6'h2b);
  assign isBeq  = (bus.opcode == 6'h04);
  assign isJ    = (bus.opcode == 6'h02);
  assign isJal  = (bus.opcode == 6'h03);

  always_comb begin
    state_d   = state_q;
    pcWr      = 1'b0;
    irWr      = 1'b0;
    regWr     = 1'b0;
    memWr     = 1'b0;
    retireRaw = 1'b0;
    npcOp     = 2'd0;
    aluOp     = 3'd0;
    aluSrc    = 1'b0;
    regDst    = 2'd0;
    wdSel     = 2'd0;
    case (state_q)
      S_IF: begin
        irWr    = 1'b1;
        pcWr    = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        if (isJ || isJr) begin
          pcWr      = 1'b1;
          npcOp     = isJ ? 2'd2 : 2'd3;
          retireRaw = 1'b1;
          state_d   = S_IF;
        end else if (isJal) begin
          pcWr    = 1'b1;
          npcOp   = 2'd2;
          state_d = S_WB;
        end else if (isBeq || isAddu || isSubu || isOri || isLui || isLw || isSw) begin
          state_d = S_EX;
        end else begin
          retireRaw = 1'b1;
          state_d   = S_IF;
        end
      end
      S_EX: begin
        if (isBeq) begin
          // Not-taken branches reload PC with the already-committed PC+4
          pcWr      = 1'b1;
          npcOp     = 2'd1;
          retireRaw = 1'b1;
          state_d   = S_IF;
        end else begin
          aluOp   = isSubu ? 3'd1 : isOri ? 3'd2 : isLui ? 3'd3 : 3'd0;
          aluSrc  = isOri || isLui || isLw || isSw;
          state_d = (isLw || isSw) ? S_MEM : S_WB;
        end
      end
      S_MEM: begin
        aluOp  = 3'd0;
        aluSrc = 1'b1;
        if (isSw) begin
          memWr     = 1'b1;
          retireRaw = 1'b1;
          state_d   = S_IF;
        end else if (isLw) begin
          state_d = S_WB;
        end else begin
          state_d = S_IF;
        end
      end
      S_WB: begin
        regWr     = 1'b1;
        retireRaw = 1'b1;
        regDst    = isJal ? 2'd2 : isR ? 2'd1 : 2'd0;
        wdSel     = isJal ? 2'd2 : isLw ? 2'd1 : 2'd0;
        state_d   = S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

  // Strobes are killed combinationally so reset and hold act within the cycle
  assign strobeEn = reset && !bus.hold;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IF;
      cnt_q   <= '0;
    end else if (!bus.hold) begin
      state_q <= state_d;
      if (retireRaw) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.PCWr      = pcWr && strobeEn;
  assign bus.IRWr      = irWr && strobeEn;
  assign bus.RegWr     = regWr && strobeEn;
  assign bus.MemWr     = memWr && strobeEn;
  assign bus.retire    = retireRaw && strobeEn;
  assign bus.NPCop     = npcOp;
  assign bus.Branchop  = 3'd0;
  assign bus.ALUop     = aluOp;
  assign bus.ALUSrc    = aluSrc;
  assign bus.RegDst    = regDst;
  assign bus.WDSel     = wdSel;
  assign bus.state     = state_q;
  assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: directed per-cycle vectors are queued by the
// driver and compared by an independent negedge monitor.
module tb_mc_ctrl;

  localparam int CW = 4;

  typedef struct packed {
    logic [2:0]    st;
    logic [4:0]    strb;   // PCWr, IRWr, RegWr, MemWr, retire
    logic [1:0]    npc;
    logic [2:0]    br;
    logic [2:0]    alu;
    logic          src;
    logic [1:0]    rdst;
    logic [1:0]    wds;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  exp_t    sb[$];
  string   names[$];
  int      nRun = 0;
  int      nFail = 0;
  logic [CW-1:0] expCnt = '0;

  mc_ctrl_if #(.CNT_W(CW)) bus ();

  mc_ctrl #(.CNT_W(CW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the hand-written expected outputs
  task automatic applyStimulus(input string nm, input logic rstN,
                               input logic [5:0] op, input logic [5:0] fn,
                               input logic hld, input logic [2:0] st,
                               input logic [4:0] strb, input logic [1:0] npc,
                               input logic [2:0] alu, input logic src,
                               input logic [1:0] rdst, input logic [1:0] wds);
    exp_t e;
    @(posedge clk);
    #1;
    reset      = rstN;
    bus.opcode = op;
    bus.funct  = fn;
    bus.hold   = hld;
    if (!rstN) expCnt = '0;
    e = '{st, strb, npc, 3'd0, alu, src, rdst, wds, expCnt};
    sb.push_back(e);
    names.push_back(nm);
    if (strb[0]) expCnt = expCnt + 1'b1;
  endtask

  task automatic cyc(input string nm, input logic [5:0] op, input logic [5:0] fn,
                     input logic [2:0] st, input logic [4:0] strb,
                     input logic [1:0] npc, input logic [2:0] alu, input logic src,
                     input logic [1:0] rdst, input logic [1:0] wds);
    applyStimulus(nm, 1'b1, op, fn, 1'b0, st, strb, npc, alu, src, rdst, wds);
  endtask

  task automatic ifc(input string nm, input logic [5:0] op, input logic [5:0] fn);
    cyc(nm, op, fn, 3'd0, 5'b11000, 2'd0, 3'd0, 1'b0, 2'd0, 2'd0);
  endtask

  task automatic checkOutput(input string nm, input exp_t e);
    exp_t a;
    a = '{bus.state, {bus.PCWr, bus.IRWr, bus.RegWr, bus.MemWr, bus.retire},
          bus.NPCop, bus.Branchop, bus.ALUop, bus.ALUSrc, bus.RegDst,
          bus.WDSel, bus.instr_cnt};
    nRun++;
    if (a !== e) begin
      nFail++;
      $display("[TB] FAIL %s: got st=%0d strb=%b npc=%0d br=%0d alu=%0d src=%0d rdst=%0d wds=%0d cnt=%0d, want st=%0d strb=%b npc=%0d br=%0d alu=%0d src=%0d rdst=%0d wds=%0d cnt=%0d",
               nm, a.st, a.strb, a.npc, a.br, a.alu, a.src, a.rdst, a.wds, a.cnt,
               e.st, e.strb, e.npc, e.br, e.alu, e.src, e.rdst, e.wds, e.cnt);
    end
  endtask

  // Monitor: compares one queued expectation per cycle, away from the edge
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) checkOutput(names.pop_front(), sb.pop_front());
    end
  end

  initial begin
    reset      = 1'b0;
    bus.opcode = 6'h00;
    bus.funct  = 6'h00;
    bus.hold   = 1'b0;

    applyStimulus("rst0", 1'b0, 6'h00, 6'h00, 1'b0, 3'd0, 5'b0, 2'd0, 3'd0, 1'b0, 2'd0, 2'd0);
    applyStimulus("rst1", 1'b0, 6'h00, 6'h00, 1'b0, 3'd0, 5'b0, 2'd0, 3'd0, 1'b0, 2'd0, 2'd0);

    ifc("ori.IF", 6'h0d, 6'h00);
    cyc("ori.ID", 6'h0d, 6'h00, 3'd1, 5'b00000, 2'd0, 3'd0, 1'b0, 2'd0, 2'd0);
    cyc("ori.EX", 6'h0d, 6'h00, 3'd2, 5'b00000, 2'd0, 3'd2, 1'b1, 2'd0, 2'd0);
    cyc("ori.WB", 6'h0d, 6'h00, 3'd4, 5'b00101, 2'd0, 3'd0, 1'b0, 2'd0, 2'd0);

    ifc("addu.IF", 6'h00, 6'h21);
    cyc("addu.ID", 6'h00, 6'h21, 3'd1, 5'b00000, 2'd0, 3'd0, 1'b0, 2'd0, 2'd0);
    cyc("addu.EX", 6'h00, 6'h21, 3'd2, 5'b00000, 2'd0, 3'd0, 1'b0, 2'd0, 2'd0);
    cyc("addu.WB", 6'h00, 6'h21, 3'd4, 5'b00101, 2'd0, 3'd0, 1'b0, 2'd1, 2'd0);

    ifc("lw.IF", 6'h23, 6'h00);
    cyc("lw.ID", 6'h23, 6'h00, 3'd1, 5'b00000, 2'd0, 3'd0, 1'b0, 2'd0, 2'd0);
    cyc("lw.EX", 6'h23, 6'h00, 3'd2, 5'b00000, 2'd0, 3'd0, 1'b1, 2'd0, 2'd0);
    cyc("lw.MEM", 6'h23, 6'h00, 3'd3, 5'b00000, 2'd0, 3'd0, 1'b1, 2'd0, 2'd0);
    cyc("lw.WB", 6'h23, 6'h00, 3'd4, 5'b00101, 2'd0, 3'd0, 1'b0, 2'd0, 2'd1);

    ifc("sw.IF", 6'h2b, 6'h00);
    cyc("sw.ID", 6'h2b, 6'h00, 3'd1, 5'b00000, 2'd0, 3'd0, 1'b0, 2'd0, 2'd0);
    cyc("sw.EX", 6'h2b, 6'h00, 3'd2, 5'b00000, 2'd0, 3'd0, 1'b1, 2'd0, 2'd0);
    cyc("sw.MEM", 6'h2b, 6'h00, 3'd3, 5'b00011, 2'd0, 3'd0, 1'b1, 2'd0, 2'd0);

    ifc("beq.IF", 6'h04, 6'h00);
    cyc("beq.ID", 6'h04, 6'h00, 3'd1, 5'b00000, 2'd0, 3'd0, 1'b0, 2'd0, 2'd0);
    cyc("beq.EX", 6'h04, 6'h00, 3'd2, 5'b10001, 2'd1, 3'd0, 1'b0, 2'd0, 2'd0);

    ifc("j.IF", 6'h02, 6'h00);
    cyc("j.ID", 6'h02, 6'h00, 3'd1, 5'b10001, 2'd2, 3'd0, 1'b0, 2'd0, 2'd0);

    ifc("jal.IF", 6'h03, 6'h00);
    cyc("jal.ID", 6'h03, 6'h00, 3'd1, 5'b10000, 2'd2, 3'd0, 1'b0, 2'd0, 2'd0);
    cyc("jal.WB", 6'h03, 6'h00, 3'd4, 5'b00101, 2'd0, 3'd0, 1'b0, 2'd2, 2'd2);

    ifc("jr.IF", 6'h00, 6'h08);
    cyc("jr.ID", 6'h00, 6'h08, 3'd1, 5'b10001, 2'd3, 3'd0, 1'b0, 2'd0, 2'd0);

    // lw held three cycles in MEM; count must be 8 entering this IF
    ifc("hlw.IF", 6'h23, 6'h00);
    cyc("hlw.ID", 6'h23, 6'h00, 3'd1, 5'b00000, 2'd0, 3'd0, 1'b0, 2'd0, 2'd0);
    cyc("hlw.EX", 6'h23, 6'h00, 3'd2, 5'b00000, 2'd0, 3'd0, 1'b1, 2'd0, 2'd0);
    for (int i = 0; i < 3; i++)
      applyStimulus("hlw.MEMhold", 1'b1, 6'h23, 6'h00, 1'b1, 3'd3, 5'b00000, 2'd0, 3'd0, 1'b1, 2'd0, 2'd0);
    cyc("hlw.MEM", 6'h23, 6'h00, 3'd3, 5'b00000, 2'd0, 3'd0, 1'b1, 2'd0, 2'd0);
    cyc("hlw.WB", 6'h23, 6'h00, 3'd4, 5'b00101, 2'd0, 3'd0, 1'b0, 2'd0, 2'd1);

    // Hold in IF suppresses IR/PC loads, then an unknown opcode acts as nop
    applyStimulus("nop.IFhold", 1'b1, 6'h3f, 6'h00, 1'b1, 3'd0, 5'b00000, 2'd0, 3'd0, 1'b0, 2'd0, 2'd0);
    ifc("nop.IF", 6'h3f, 6'h00);
    cyc("nop.ID", 6'h3f, 6'h00, 3'd1, 5'b00001, 2'd0, 3'd0, 1'b0, 2'd0, 2'd0);

    // Async reset in the middle of addu EX
    ifc("radd.IF", 6'h00, 6'h21);
    cyc("radd.ID", 6'h00, 6'h21, 3'd1, 5'b00000, 2'd0, 3'd0, 1'b0, 2'd0, 2'd0);
    cyc("radd.EX", 6'h00, 6'h21, 3'd2, 5'b00000, 2'd0, 3'd0, 1'b0, 2'd0, 2'd0);
    #6;
    reset = 1'b0;
    #1;
    nRun++;
    if (bus.state !== 3'd0 || bus.RegWr !== 1'b0 || bus.PCWr !== 1'b0 ||
        bus.IRWr !== 1'b0 || bus.instr_cnt !== '0) begin
      nFail++;
      $display("[TB] FAIL async_reset: got st=%0d RegWr=%b PCWr=%b IRWr=%b cnt=%0d, want st=0 strobes=0 cnt=0",
               bus.state, bus.RegWr, bus.PCWr, bus.IRWr, bus.instr_cnt);
    end
    applyStimulus("radd.rst", 1'b0, 6'h00, 6'h21, 1'b0, 3'd0, 5'b0, 2'd0, 3'd0, 1'b0, 2'd0, 2'd0);

    // 16 jumps wrap the 4-bit counter back to 0
    for (int i = 0; i < 16; i++) begin
      ifc("wrap.IF", 6'h02, 6'h00);
      cyc("wrap.ID", 6'h02, 6'h00, 3'd1, 5'b10001, 2'd2, 3'd0, 1'b0, 2'd0, 2'd0);
    end
    ifc("wrap.final", 6'h00, 6'h00);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      nRun++;
      nFail++;
      $display("[TB] FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $finish;
  end

endmodule
